// File: rtl/pipelined_sdiv.sv
// Pipelined restoring divider for signed or unsigned operands, STEPS quotient bits per stage.
// Input stage takes magnitudes; the last division stage restores signs and registers the outputs.
module pipelined_sdiv #(
    parameter int DIVIDENDLEN = 16,
    parameter int DIVISORLEN  = 8,
    parameter int STEPS       = 1,
    parameter int TAGW        = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_signed,
    input  logic [DIVIDENDLEN-1:0] dividend,
    input  logic [DIVISORLEN-1:0]  divisor,
    input  logic [TAGW-1:0]        in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DIVIDENDLEN-1:0] quotient,
    output logic [DIVISORLEN-1:0]  remainder,
    output logic                   div_zero,
    output logic                   overflow,
    output logic [TAGW-1:0]        out_tag
);
    localparam int DL  = DIVIDENDLEN;
    localparam int VL  = DIVISORLEN;
    localparam int W   = DL + VL - 1;
    localparam int NST = DL / STEPS;

    if ((DL % STEPS) != 0 || VL > DL || VL < 2 || DL < 2) begin : g_bad_param
        $error("pipelined_sdiv: illegal parameter combination");
    end

    typedef struct packed {
        logic            vld;
        logic            dz;
        logic            ovf;
        logic            qneg;
        logic            rneg;
        logic [W-1:0]    rem;
        logic [DL-1:0]   quo;
        logic [VL-1:0]   dvs;
        logic [TAGW-1:0] tag;
    } stage_t;

    stage_t st_q [NST];
    stage_t st_d [NST];

    logic            out_valid_q, out_valid_d;
    logic [DL-1:0]   quotient_q, quotient_d;
    logic [VL-1:0]   remainder_q, remainder_d;
    logic            div_zero_q, div_zero_d;
    logic            overflow_q, overflow_d;
    logic [TAGW-1:0] out_tag_q, out_tag_d;

    logic            advance;
    logic            a_neg, b_neg;
    logic [DL-1:0]   a_mag;
    logic [VL-1:0]   b_mag;
    logic [VL-1:0]   r_mag;
    logic [W-1:0]    trial;
    stage_t          s;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    always_comb begin
        s     = '0;
        trial = '0;
        a_neg = in_signed & dividend[DL-1];
        b_neg = in_signed & divisor[VL-1];
        a_mag = a_neg ? -dividend : dividend;
        b_mag = b_neg ? -divisor : divisor;

        st_d[0]      = '0;
        st_d[0].vld  = in_valid;
        st_d[0].dz   = (divisor == '0);
        st_d[0].ovf  = in_signed && (dividend == {1'b1, {(DL-1){1'b0}}}) && (divisor == '1);
        st_d[0].qneg = a_neg ^ b_neg;
        st_d[0].rneg = a_neg;
        st_d[0].rem  = W'(a_mag);
        st_d[0].dvs  = b_mag;
        st_d[0].tag  = in_tag;

        // Quotient bits come out MSB first, so they are shifted in from the bottom.
        for (int k = 1; k <= NST; k++) begin
            s = st_q[k-1];
            for (int j = 0; j < STEPS; j++) begin
                trial = W'(s.dvs) << (DL - 1 - (k - 1) * STEPS - j);
                if (s.rem >= trial) begin
                    s.rem = s.rem - trial;
                    s.quo = {s.quo[DL-2:0], 1'b1};
                end else begin
                    s.quo = {s.quo[DL-2:0], 1'b0};
                end
            end
            if (k < NST) st_d[k % NST] = s;
        end

        r_mag       = s.rem[VL-1:0];
        out_valid_d = s.vld;
        div_zero_d  = s.dz;
        overflow_d  = s.ovf;
        out_tag_d   = s.tag;
        if (s.dz) begin
            quotient_d  = '1;
            remainder_d = '0;
        end else begin
            quotient_d  = s.qneg ? -s.quo : s.quo;
            remainder_d = s.rneg ? -r_mag : r_mag;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NST; k++) st_q[k] <= '0;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
            out_tag_q   <= '0;
        end else if (advance) begin
            for (int k = 0; k < NST; k++) st_q[k] <= st_d[k];
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_pipelined_sdiv.sv
// Bench for pipelined_sdiv: directed vector table, stall/reset sequences, and
// randomized traffic on STEPS = 1, 2, 4 instances checked against an arithmetic model.
module tb_pipelined_sdiv;
    localparam int DL    = 16;
    localparam int VL    = 8;
    localparam int TW    = 4;
    localparam int LAT   = 17;
    localparam int NRAND = 3400;
    localparam int NV    = 12;

    typedef struct packed {
        logic [DL-1:0] q;
        logic [VL-1:0] r;
        logic          dz;
        logic          ovf;
    } res_t;

    typedef struct {
        logic          sg;
        logic [DL-1:0] a;
        logic [VL-1:0] b;
        logic [TW-1:0] tag;
        logic [DL-1:0] q;
        logic [VL-1:0] r;
        logic          dz;
        logic          ovf;
    } vec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    logic          in_valid, in_ready, in_signed, out_valid, out_ready, div_zero, overflow;
    logic [DL-1:0] dividend, quotient;
    logic [VL-1:0] divisor, remainder;
    logic [TW-1:0] in_tag, out_tag;
    int checks = 0;
    int errors = 0;
    bit rand_go = 1'b0;

    pipelined_sdiv #(.DIVIDENDLEN(DL), .DIVISORLEN(VL), .STEPS(1), .TAGW(TW)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
        .remainder(remainder), .div_zero(div_zero), .overflow(overflow), .out_tag(out_tag)
    );

    // Truncating division straight from the arithmetic definition.
    function automatic res_t ref_div(input logic sg, input logic [DL-1:0] a, input logic [VL-1:0] b);
        res_t o;
        int   sa, sb;
        o = '0;
        if (b == 0) begin
            o.q  = '1;
            o.dz = 1'b1;
        end else if (!sg) begin
            o.q = a / DL'(b);
            o.r = VL'(a % DL'(b));
        end else begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -32768 && sb == -1) begin
                o.q   = 16'h8000;
                o.ovf = 1'b1;
            end else begin
                o.q = DL'(sa / sb);
                o.r = VL'(sa % sb);
            end
        end
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_one(input logic sg, input logic [DL-1:0] a, input logic [VL-1:0] b,
                           input logic [TW-1:0] tag, output logic [29:0] rec,
                           output logic early, output logic vld);
        @(negedge clock);
        in_valid = 1'b1; in_signed = sg; dividend = a; divisor = b; in_tag = tag;
        @(posedge clock);                 // acceptance edge counts as edge 1
        @(negedge clock);
        in_valid = 1'b0;
        repeat (LAT - 2) @(posedge clock);
        @(negedge clock);
        early = out_valid;
        @(posedge clock);
        @(negedge clock);
        vld = out_valid;
        rec = {quotient, remainder, div_zero, overflow, out_tag};
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
        localparam int ST = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
        logic          iv, ir, isg, ov, ordy, dz, ovf;
        logic [DL-1:0] a, q;
        logic [VL-1:0] b, r;
        logic [TW-1:0] t, ot;
        logic [29:0]   expq[$];
        bit            done = 1'b0;

        pipelined_sdiv #(.DIVIDENDLEN(DL), .DIVISORLEN(VL), .STEPS(ST), .TAGW(TW)) u (
            .clock(clock), .reset_n(reset_n), .in_valid(iv), .in_ready(ir),
            .in_signed(isg), .dividend(a), .divisor(b), .in_tag(t),
            .out_valid(ov), .out_ready(ordy), .quotient(q), .remainder(r),
            .div_zero(dz), .overflow(ovf), .out_tag(ot)
        );

        initial begin
            int   sent;
            int   idle;
            res_t e;
            sent = 0; idle = 0;
            iv = 1'b0; isg = 1'b0; a = '0; b = '0; t = '0; ordy = 1'b0;
            wait (rand_go);
            while ((sent < NRAND || expq.size() != 0) && idle < 2000) begin
                @(negedge clock);
                iv   = (sent < NRAND) && ($urandom_range(0, 9) < 7);
                isg  = 1'($urandom_range(0, 1));
                a    = ($urandom_range(0, 15) == 0) ? 16'h8000 : DL'($urandom);
                case ($urandom_range(0, 9))
                    0:       b = 8'h00;
                    1:       b = 8'hFF;
                    2:       b = 8'h80;
                    3:       b = 8'h01;
                    default: b = VL'($urandom);
                endcase
                t    = TW'($urandom);
                ordy = ($urandom_range(0, 9) < 7);
                #1;
                if (ov && ordy) begin
                    idle = 0;
                    if (expq.size() == 0) chk($sformatf("rand_s%0d_unexpected", ST), 64'(ov), 64'(0));
                    else chk($sformatf("rand_s%0d_result", ST), 64'({q, r, dz, ovf, ot}), 64'(expq.pop_front()));
                end else begin
                    idle++;
                end
                if (iv && ir) begin
                    e = ref_div(isg, a, b);
                    expq.push_back({e.q, e.r, e.dz, e.ovf, t});
                    sent++;
                end
            end
            iv = 1'b0;
            chk($sformatf("rand_s%0d_sent", ST), 64'(sent), 64'(NRAND));
            chk($sformatf("rand_s%0d_drain", ST), 64'(expq.size()), 64'(0));
            done = 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[NV];
        logic [29:0] rec, held;
        logic        early, vld;
        logic [29:0] exp_s[$];
        int          issued, got_n, cyc, n, stale;
        res_t        e;

        tbl[0]  = '{1'b0, 16'd100,   8'd7,    4'd3, 16'd14,   8'd2,   1'b0, 1'b0};
        tbl[1]  = '{1'b1, 16'hFF9C,  8'd7,    4'd1, 16'hFFF2, 8'hFE,  1'b0, 1'b0};
        tbl[2]  = '{1'b0, 16'd65535, 8'd255,  4'd2, 16'd257,  8'd0,   1'b0, 1'b0};
        tbl[3]  = '{1'b0, 16'd1234,  8'd0,    4'd4, 16'hFFFF, 8'd0,   1'b1, 1'b0};
        tbl[4]  = '{1'b1, 16'd1234,  8'd0,    4'd5, 16'hFFFF, 8'd0,   1'b1, 1'b0};
        tbl[5]  = '{1'b1, 16'h8000,  8'hFF,   4'd6, 16'h8000, 8'd0,   1'b0, 1'b1};
        tbl[6]  = '{1'b0, 16'h8000,  8'hFF,   4'd7, 16'd128,  8'd128, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 16'd7,     8'hFE,   4'd8, 16'hFFFD, 8'd1,   1'b0, 1'b0};
        tbl[8]  = '{1'b1, 16'hFFF9,  8'hFE,   4'd9, 16'd3,    8'hFF,  1'b0, 1'b0};
        tbl[9]  = '{1'b1, 16'h7FFF,  8'h80,   4'hA, 16'hFF01, 8'h7F,  1'b0, 1'b0};
        tbl[10] = '{1'b0, 16'hFFFF,  8'd1,    4'hB, 16'hFFFF, 8'd0,   1'b0, 1'b0};
        tbl[11] = '{1'b1, 16'hFFFF,  8'd1,    4'hC, 16'hFFFF, 8'd0,   1'b0, 1'b0};

        in_valid = 1'b0; in_signed = 1'b0; dividend = '0; divisor = '0; in_tag = '0;
        out_ready = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_outputs", 64'({quotient, remainder, div_zero, overflow, out_tag}), 64'(0));
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_one(tbl[i].sg, tbl[i].a, tbl[i].b, tbl[i].tag, rec, early, vld);
            chk($sformatf("vec%0d_not_early", i), 64'(early), 64'(0));
            chk($sformatf("vec%0d_valid_at_lat", i), 64'(vld), 64'(1));
            chk($sformatf("vec%0d_result", i), 64'(rec),
                64'({tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ovf, tbl[i].tag}));
        end

        // 20 back-to-back requests with the consumer stalled for cycles 18..22.
        issued = 0; got_n = 0; cyc = 0; held = '0;
        while (got_n < 20 && cyc < 200) begin
            @(negedge clock);
            out_ready = !(cyc >= 18 && cyc <= 22);
            in_valid  = (issued < 20);
            if (issued < 20) begin
                in_signed = issued[0];
                dividend  = DL'(issued * 2377 + 5);
                divisor   = VL'(issued * 13 + 3);
                in_tag    = TW'(issued);
            end
            #1;
            chk("stream_in_ready", 64'(in_ready), 64'(!(cyc >= 18 && cyc <= 22)));
            if (cyc == 18) held = {quotient, remainder, div_zero, overflow, out_tag};
            if (cyc > 18 && cyc <= 22)
                chk("stream_hold", 64'({quotient, remainder, div_zero, overflow, out_tag}), 64'(held));
            if (out_valid && out_ready) begin
                if (exp_s.size() == 0) chk("stream_unexpected", 64'(out_valid), 64'(0));
                else chk("stream_result", 64'({quotient, remainder, div_zero, overflow, out_tag}),
                         64'(exp_s.pop_front()));
                got_n++;
            end
            if (in_valid && in_ready) begin
                e = ref_div(in_signed, dividend, divisor);
                exp_s.push_back({e.q, e.r, e.dz, e.ovf, in_tag});
                issued++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_count", 64'(got_n), 64'(20));

        // Reset with 8 requests in flight and the first result being held.
        @(negedge clock);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_signed = 1'b0; dividend = DL'(1000 + i); divisor = 8'd3; in_tag = TW'(i);
            @(negedge clock);
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("pre_reset_out_valid", 64'(out_valid), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_out_valid", 64'(out_valid), 64'(0));
        chk("async_reset_outputs", 64'({quotient, remainder, div_zero, overflow, out_tag}), 64'(0));
        chk("async_reset_in_ready", 64'(in_ready), 64'(1));
        repeat (2) @(negedge clock);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (40) begin
            @(negedge clock);
            if (out_valid) stale++;
        end
        chk("no_stale_after_reset", 64'(stale), 64'(0));
        run_one(1'b1, 16'hFC18, 8'hF9, 4'hA, rec, early, vld);
        chk("post_reset_not_early", 64'(early), 64'(0));
        chk("post_reset_valid", 64'(vld), 64'(1));
        chk("post_reset_result", 64'(rec), 64'({16'h008E, 8'hFA, 1'b0, 1'b0, 4'hA}));

        rand_go = 1'b1;
        wait (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
